// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Round-robin time-multiplexing of one external 32-bit ripple-carry adder
//   between NUM_REQ requesters. Operands are registered onto add_a/add_b and
//   held for SETTLE_CYCLES cycles before the external add_sum is sampled.
//   Exactly one operation is in flight at a time.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid    per-requester request
//   req_ready    per-requester accept (one-hot, only in IDLE)
//   req_a/req_b  packed operands, requester i at [32i+31:32i]
//   add_a/add_b  registered operands to the shared adder
//   add_sum      33-bit sum back from the shared adder
//   rsp_valid/rsp_ready/rsp_id/rsp_sum  shared tagged response channel
//   busy         high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module adder_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  input  logic [32:0]            add_sum,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [32:0]            rsp_sum,
  output logic                   busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [ID_W-1:0]    rr_ptr_r;

  logic [NUM_REQ-1:0] rot_s;
  logic               found_s;
  logic [ID_W:0]      offset_s;
  logic [ID_W:0]      grant_sum_s;
  logic [ID_W-1:0]    grant_s;
  logic               accept_s;
  logic [31:0]        sel_a_s;
  logic [31:0]        sel_b_s;
  logic [ID_W:0]      next_ptr_sum_s;
  logic [ID_W-1:0]    next_ptr_s;

  // Rotate the request vector so bit 0 is the requester at rr_ptr.
  assign rot_s = NUM_REQ'({req_valid, req_valid} >> rr_ptr_r);

  // Priority search from the rotated bit 0; descending loop leaves the lowest hit.
  always_comb begin
    found_s  = |rot_s;
    offset_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      offset_s = rot_s[k] ? (ID_W+1)'(k) : offset_s;
    end
  end

  // Map rotated offset back to an absolute requester index (mod NUM_REQ).
  always_comb begin
    grant_sum_s = {1'b0, rr_ptr_r} + offset_s;
    grant_s     = (grant_sum_s >= NUM_REQ_W) ? ID_W'(grant_sum_s - NUM_REQ_W)
                                             : ID_W'(grant_sum_s);
  end

  // A grant is offered only in IDLE with some request pending; held off in reset.
  assign accept_s = rst_n && (state_r == IDLE) && found_s;

  // One-hot ready and operand mux for the granted requester.
  always_comb begin
    req_ready = '0;
    sel_a_s   = 32'd0;
    sel_b_s   = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = accept_s && (grant_s == ID_W'(k));
      sel_a_s      = (grant_s == ID_W'(k)) ? req_a[32*k +: 32] : sel_a_s;
      sel_b_s      = (grant_s == ID_W'(k)) ? req_b[32*k +: 32] : sel_b_s;
    end
  end

  // Pointer for the next round: one past the requester just served.
  always_comb begin
    next_ptr_sum_s = {1'b0, rsp_id} + (ID_W+1)'(1);
    next_ptr_s     = (next_ptr_sum_s >= NUM_REQ_W) ? '0 : ID_W'(next_ptr_sum_s);
  end

  // Busy is a decode of the registered state.
  always_comb begin
    busy = (state_r != IDLE);
  end

  // Main FSM: accept, hold operands while the ripple path settles, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      rr_ptr_r  <= '0;
      add_a     <= 32'd0;
      add_b     <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= 33'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            add_a   <= sel_a_s;
            add_b   <= sel_b_s;
            rsp_id  <= grant_s;
            cnt_r   <= CNT_INIT;
            state_r <= SETTLE;
          end else begin
            state_r <= IDLE;
          end
        end
        SETTLE: begin
          if (cnt_r == '0) begin
            rsp_sum   <= add_sum;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr_r  <= next_ptr_s;
            state_r   <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed table, hand-written corner
// sequences and randomized transactions against a round-robin reference model.
module tb_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int SETTLE  = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic [32:0]           add_sum;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [32:0]           rsp_sum;
  logic                  busy;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;
  logic [31:0] op_a [NUM_REQ];
  logic [31:0] op_b [NUM_REQ];

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] a;
    logic [31:0] b;
    int          wait_cyc;
    int          exp_id;
    logic [32:0] exp_sum;
  } vec_t;

  vec_t tbl [7];

  adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
  );

  // External shared adder (carry-in tied 0)
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
    end
  endtask

  task automatic scramble_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = $urandom();
      op_b[i] = $urandom();
    end
    drive_ops();
  endtask

  // One transaction starting at the beginning of an IDLE cycle.
  task automatic serve(input logic [3:0] mask, input int wait_cyc, input bit keep,
                       input bit use_tbl, input int tbl_id, input logic [32:0] tbl_sum);
    int g;
    int idx;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [32:0] es;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (model_ptr + k) % NUM_REQ;
      if (g < 0 && mask[idx]) g = idx;
    end
    if (use_tbl) g = tbl_id;
    req_valid = mask;
    drive_ops();
    rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
    if (g < 0) begin
      chk("no_req_ready", req_ready, 0);
      @(posedge clk); #1;
      return;
    end
    chk("grant_ready", req_ready, 4'b0001 << g);
    ea = op_a[g];
    eb = op_b[g];
    es = use_tbl ? tbl_sum : ({1'b0, ea} + {1'b0, eb});
    @(posedge clk); #1;
    for (int c = 1; c <= SETTLE; c++) begin
      if (!keep) begin
        req_valid = 4'($urandom_range(0, 15));
        scramble_ops();
      end
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("settle_rsp_valid", rsp_valid, 0);
      chk("settle_busy", busy, 1);
      chk("settle_ready", req_ready, 0);
      chk("settle_add_a", add_a, ea);
      chk("settle_add_b", add_b, eb);
      @(posedge clk); #1;
    end
    for (int r = 0; r <= wait_cyc; r++) begin
      rsp_ready = (r == wait_cyc);
      if (!keep) req_valid = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, g);
      chk("rsp_sum", rsp_sum, es);
      chk("resp_busy", busy, 1);
      chk("resp_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    model_ptr = (g + 1) % NUM_REQ;
    if (!keep) req_valid = 4'b0000;
    rsp_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4'b0001, 32'h0000_0005, 32'h0000_0003, 0, 0, 33'h0_0000_0008};
    tbl[1] = '{4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 5, 2, 33'h1_0000_0000};
    tbl[2] = '{4'b1000, 32'h8000_0000, 32'h8000_0000, 1, 3, 33'h1_0000_0000};
    tbl[3] = '{4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 33'h1_FFFF_FFFE};
    tbl[4] = '{4'b0011, 32'h1234_5678, 32'h1111_1111, 2, 0, 33'h0_2345_6789};
    tbl[5] = '{4'b1111, 32'h0000_0000, 32'h0000_0000, 0, 1, 33'h0_0000_0000};
    tbl[6] = '{4'b1001, 32'h7FFF_FFFF, 32'h0000_0001, 0, 3, 33'h0_8000_0000};

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;

    // Reset state
    @(negedge clk);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    req_valid = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ptr = 0;

    // Directed table
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        op_a[i] = tbl[t].a;
        op_b[i] = tbl[t].b;
      end
      serve(tbl[t].mask, tbl[t].wait_cyc, 1'b0, 1'b1, tbl[t].exp_id, tbl[t].exp_sum);
    end

    // All four valid continuously: order 0,1,2,3,0 back to back
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = 32'h1000_0000 * (i + 1);
      op_b[i] = 32'h0000_0100 + i;
    end
    for (int n = 0; n < 5; n++) begin
      chk("rr_model_order", model_ptr, n % NUM_REQ);
      serve(4'b1111, 0, 1'b1, 1'b0, 0, 33'd0);
    end
    req_valid = 4'b0000;

    // Only requester 3 valid, repeatedly
    for (int n = 0; n < 3; n++) begin
      op_a[3] = $urandom();
      op_b[3] = $urandom();
      serve(4'b1000, n, 1'b0, 1'b1, 3, {1'b0, op_a[3]} + {1'b0, op_b[3]});
    end

    // Asynchronous reset during SETTLE with requester 1 in flight
    op_a[1] = 32'hAAAA_5555;
    op_b[1] = 32'h1234_0000;
    drive_ops();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("abort_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_add_a", add_a, 0);
    chk("abort_add_b", add_b, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_id", rsp_id, 0);
    chk("abort_rsp_sum", rsp_sum, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    model_ptr = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_abort_rsp_valid", rsp_valid, 0);
      chk("post_abort_busy", busy, 0);
      @(posedge clk); #1;
    end
    op_a[0] = 32'h0000_0010;
    op_b[0] = 32'h0000_0020;
    serve(4'b0011, 0, 1'b0, 1'b1, 0, 33'h0_0000_0030);

    // Randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      scramble_ops();
      serve(4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0, 1'b0, 0, 33'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
